// File: rtl/id_ex_issue.sv
// RV32I decode/issue: decodes the fetched instruction into ALU operands and EX controls, and registers them into ID/EX.
// One cycle from accept to out_valid; stalls on load-use and then inserts a one-cycle bubble; flush empties the register.
module id_ex_issue #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic [4:0]      rs1_addr,
   output logic [4:0]      rs2_addr,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] ex_op1,
   output logic [XLEN-1:0] ex_op2,
   output logic [4:0]      ex_alu_control,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_rd,
   output logic            ex_reg_write,
   output logic            ex_mem_read,
   output logic            ex_mem_write,
   output logic [2:0]      ex_funct3,
   output logic            ex_is_branch,
   output logic            ex_is_jump,
   output logic            ex_illegal
);
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef struct packed {
      logic [XLEN-1:0] op1;
      logic [XLEN-1:0] op2;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [4:0]      alu_control;
      logic [4:0]      rd;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic [2:0]      funct3;
      logic            is_branch;
      logic            is_jump;
      logic            illegal;
   } ex_t;

   logic [6:0]      opcode;
   logic [6:0]      funct7;
   logic [2:0]      funct3;
   logic [4:0]      rd;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, upper20, shamt;

   ex_t  dec;
   logic legal, uses_rs1, uses_rs2;
   logic load_use, transfer;

   ex_t  ex_d, ex_q;
   logic out_valid_d, out_valid_q;
   logic bubble_d, bubble_q;

   assign opcode   = in_instr[6:0];
   assign rd       = in_instr[11:7];
   assign funct3   = in_instr[14:12];
   assign funct7   = in_instr[31:25];
   assign rs1_addr = in_instr[19:15];
   assign rs2_addr = in_instr[24:20];

   assign imm_i   = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
   assign imm_s   = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b   = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
   assign imm_j   = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
   assign imm_u   = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};
   // The ALU applies the <<12 for LUI/AUIPC itself, so op2 carries the raw 20-bit field.
   assign upper20 = {{(XLEN-20){1'b0}}, in_instr[31:12]};
   assign shamt   = {{(XLEN-5){1'b0}}, in_instr[24:20]};

   function automatic logic [4:0] alu_of_funct3(input logic [2:0] f3);
      case (f3)
         3'b000:  alu_of_funct3 = 5'b00000;
         3'b001:  alu_of_funct3 = 5'b00101;
         3'b010:  alu_of_funct3 = 5'b01000;
         3'b011:  alu_of_funct3 = 5'b01001;
         3'b100:  alu_of_funct3 = 5'b00010;
         3'b101:  alu_of_funct3 = 5'b00110;
         3'b110:  alu_of_funct3 = 5'b00011;
         default: alu_of_funct3 = 5'b00100;
      endcase
   endfunction

   always_comb begin
      dec        = '0;
      legal      = 1'b1;
      uses_rs1   = 1'b0;
      uses_rs2   = 1'b0;
      dec.pc     = in_pc;
      dec.funct3 = funct3;
      case (opcode)
         OP_R: begin
            uses_rs1      = 1'b1;
            uses_rs2      = 1'b1;
            dec.op1       = rs1_data;
            dec.op2       = rs2_data;
            dec.rd        = rd;
            dec.reg_write = 1'b1;
            if (funct7 == 7'b0000000)
               dec.alu_control = alu_of_funct3(funct3);
            else if (funct7 == 7'b0100000 && funct3 == 3'b000)
               dec.alu_control = 5'b00001;
            else if (funct7 == 7'b0100000 && funct3 == 3'b101)
               dec.alu_control = 5'b00111;
            else
               legal = 1'b0;
         end
         OP_IMM: begin
            uses_rs1        = 1'b1;
            dec.op1         = rs1_data;
            dec.op2         = imm_i;
            dec.imm         = imm_i;
            dec.rd          = rd;
            dec.reg_write   = 1'b1;
            dec.alu_control = alu_of_funct3(funct3);
            if (funct3 == 3'b001 || funct3 == 3'b101) begin
               dec.op2 = shamt;
               if (funct7 == 7'b0100000 && funct3 == 3'b101)
                  dec.alu_control = 5'b00111;
               else if (funct7 != 7'b0000000)
                  legal = 1'b0;
            end
         end
         OP_LOAD: begin
            uses_rs1      = 1'b1;
            dec.op1       = rs1_data;
            dec.op2       = imm_i;
            dec.imm       = imm_i;
            dec.rd        = rd;
            dec.reg_write = 1'b1;
            dec.mem_read  = 1'b1;
            legal         = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
         end
         OP_STORE: begin
            uses_rs1      = 1'b1;
            uses_rs2      = 1'b1;
            dec.op1       = rs1_data;
            dec.op2       = imm_s;
            dec.imm       = imm_s;
            dec.mem_write = 1'b1;
            legal         = !funct3[2] && (funct3 != 3'b011);
         end
         OP_BRANCH: begin
            uses_rs1      = 1'b1;
            uses_rs2      = 1'b1;
            dec.op1       = rs1_data;
            dec.op2       = rs2_data;
            dec.imm       = imm_b;
            dec.is_branch = 1'b1;
            case (funct3)
               3'b000:  dec.alu_control = 5'b01010;
               3'b001:  dec.alu_control = 5'b01011;
               3'b100:  dec.alu_control = 5'b01100;
               3'b101:  dec.alu_control = 5'b01101;
               3'b110:  dec.alu_control = 5'b01110;
               3'b111:  dec.alu_control = 5'b01111;
               default: legal = 1'b0;
            endcase
         end
         OP_LUI, OP_AUIPC: begin
            dec.op2         = upper20;
            dec.imm         = imm_u;
            dec.rd          = rd;
            dec.reg_write   = 1'b1;
            dec.alu_control = (opcode == OP_LUI) ? 5'b10000 : 5'b10001;
         end
         OP_JAL: begin
            dec.op2         = imm_j;
            dec.imm         = imm_j;
            dec.rd          = rd;
            dec.reg_write   = 1'b1;
            dec.is_jump     = 1'b1;
            dec.alu_control = 5'b10010;
         end
         OP_JALR: begin
            uses_rs1        = 1'b1;
            dec.op1         = rs1_data;
            dec.op2         = imm_i;
            dec.imm         = imm_i;
            dec.rd          = rd;
            dec.reg_write   = 1'b1;
            dec.is_jump     = 1'b1;
            dec.alu_control = 5'b10011;
            legal           = (funct3 == 3'b000);
         end
         default: legal = 1'b0;
      endcase
      // Illegal instructions still flow down the pipe, but with every side effect stripped.
      if (!legal) begin
         dec         = '0;
         dec.pc      = in_pc;
         dec.illegal = 1'b1;
      end
      if (dec.rd == 5'd0)
         dec.reg_write = 1'b0;
   end

   assign load_use = in_valid && out_valid_q && ex_q.mem_read && (ex_q.rd != 5'd0) &&
                     ((uses_rs1 && rs1_addr == ex_q.rd) || (uses_rs2 && rs2_addr == ex_q.rd));
   assign in_ready = (!out_valid_q || out_ready) && !bubble_q && !flush && !load_use;
   assign transfer = in_valid && in_ready;

   always_comb begin
      ex_d        = ex_q;
      out_valid_d = out_valid_q;
      bubble_d    = 1'b0;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (transfer) begin
         ex_d        = dec;
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
         bubble_d    = load_use;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         bubble_q    <= 1'b0;
         ex_q        <= '0;
         ex_q.pc     <= RESET_PC;
      end else begin
         out_valid_q <= out_valid_d;
         bubble_q    <= bubble_d;
         ex_q        <= ex_d;
      end
   end

   assign out_valid      = out_valid_q;
   assign ex_op1         = ex_q.op1;
   assign ex_op2         = ex_q.op2;
   assign ex_alu_control = ex_q.alu_control;
   assign ex_pc          = ex_q.pc;
   assign ex_imm         = ex_q.imm;
   assign ex_rd          = ex_q.rd;
   assign ex_reg_write   = ex_q.reg_write;
   assign ex_mem_read    = ex_q.mem_read;
   assign ex_mem_write   = ex_q.mem_write;
   assign ex_funct3      = ex_q.funct3;
   assign ex_is_branch   = ex_q.is_branch;
   assign ex_is_jump     = ex_q.is_jump;
   assign ex_illegal     = ex_q.illegal;
endmodule

// File: tb/tb_id_ex_issue.sv
// Bench for id_ex_issue: fixed decode vectors, hand-built stall/flush/reset sequences, then random traffic against a reference model.
module tb_id_ex_issue;
   localparam logic [31:0] RST_PC = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] in_instr, in_pc, rs1_data, rs2_data;
   logic [4:0]  rs1_addr, rs2_addr, ex_alu_control, ex_rd;
   logic [31:0] ex_op1, ex_op2, ex_pc, ex_imm;
   logic [2:0]  ex_funct3;
   logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch, ex_is_jump, ex_illegal;

   always #5 clk = ~clk;

   id_ex_issue #(.XLEN(32), .RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .in_pc(in_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data),
      .rs2_data(rs2_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_alu_control(ex_alu_control), .ex_pc(ex_pc),
      .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3), .ex_is_branch(ex_is_branch),
      .ex_is_jump(ex_is_jump), .ex_illegal(ex_illegal));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp_v);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [31:0] op1, op2, imm;
      logic [4:0]  alu, rd;
      logic [2:0]  f3;
      logic rw, mr, mw, br, jp, ill, u1, u2, c_op1, c_rd, c_imm, c_f3;
   } exp_t;

   // ALU codes listed in the order ADD,SUB,XOR,OR,AND,SLL,SRL,SRA,SLT,SLTU are 0..9; index by funct3.
   logic [4:0] f3_code [0:7] = '{5'd0, 5'd5, 5'd8, 5'd9, 5'd2, 5'd6, 5'd3, 5'd4};

   function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
      exp_t e;
      logic ok;
      logic [6:0] op, f7;
      logic [2:0] f3;
      logic [31:0] iimm, simm, bimm, jimm;
      op = ins[6:0]; f7 = ins[31:25]; f3 = ins[14:12];
      iimm = {{20{ins[31]}}, ins[31:20]};
      simm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      bimm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      jimm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      e = '0; ok = 1'b1;
      if (op == 7'h33) begin
         e.u1 = 1; e.u2 = 1; e.op1 = r1; e.op2 = r2; e.rw = 1; e.c_op1 = 1; e.c_rd = 1;
         if (f7 == 0) e.alu = f3_code[f3];
         else if (f7 == 7'h20 && f3 == 0) e.alu = 5'd1;
         else if (f7 == 7'h20 && f3 == 5) e.alu = 5'd7;
         else ok = 0;
      end else if (op == 7'h13) begin
         e.u1 = 1; e.op1 = r1; e.rw = 1; e.c_op1 = 1; e.c_rd = 1;
         if (f3 == 1 || f3 == 5) begin
            e.op2 = 32'(ins[24:20]);
            if (f7 == 0) e.alu = (f3 == 1) ? 5'd5 : 5'd6;
            else if (f7 == 7'h20 && f3 == 5) e.alu = 5'd7;
            else ok = 0;
         end else begin
            e.op2 = iimm; e.alu = f3_code[f3];
         end
      end else if (op == 7'h03) begin
         e.u1 = 1; e.op1 = r1; e.op2 = iimm; e.mr = 1; e.rw = 1; e.c_op1 = 1; e.c_rd = 1; e.c_f3 = 1;
         ok = (f3 <= 2) || f3 == 4 || f3 == 5;
      end else if (op == 7'h23) begin
         e.u1 = 1; e.u2 = 1; e.op1 = r1; e.op2 = simm; e.mw = 1; e.c_op1 = 1; e.c_f3 = 1;
         ok = (f3 <= 2);
      end else if (op == 7'h63) begin
         e.u1 = 1; e.u2 = 1; e.op1 = r1; e.op2 = r2; e.br = 1; e.imm = bimm; e.c_op1 = 1; e.c_imm = 1;
         ok = (f3 != 2 && f3 != 3);
         e.alu = 5'(10 + ((f3 < 2) ? f3 : f3 - 2));
      end else if (op == 7'h37 || op == 7'h17) begin
         e.op2 = {12'b0, ins[31:12]}; e.rw = 1; e.c_rd = 1;
         e.alu = (op == 7'h37) ? 5'd16 : 5'd17;
      end else if (op == 7'h6F) begin
         e.op2 = jimm; e.alu = 5'd18; e.rw = 1; e.jp = 1; e.c_rd = 1;
      end else if (op == 7'h67) begin
         e.u1 = 1; e.op1 = r1; e.op2 = iimm; e.alu = 5'd19; e.rw = 1; e.jp = 1; e.c_op1 = 1; e.c_rd = 1;
         ok = (f3 == 0);
      end else begin
         ok = 0;
      end
      if (!ok) begin
         e.alu = 0; e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.jp = 0; e.ill = 1;
         e.c_op1 = 0; e.c_rd = 0; e.c_imm = 0; e.c_f3 = 0;
      end
      e.f3 = f3;
      e.rd = ins[11:7];
      if (e.rd == 0) e.rw = 0;
      return e;
   endfunction

   task automatic check_model(input exp_t e, input logic [31:0] pc);
      chk("m_alu", ex_alu_control, e.alu);
      chk("m_reg_write", ex_reg_write, e.rw);
      chk("m_mem_read", ex_mem_read, e.mr);
      chk("m_mem_write", ex_mem_write, e.mw);
      chk("m_is_branch", ex_is_branch, e.br);
      chk("m_is_jump", ex_is_jump, e.jp);
      chk("m_illegal", ex_illegal, e.ill);
      chk("m_pc", ex_pc, pc);
      if (!e.ill) chk("m_op2", ex_op2, e.op2);
      if (e.c_op1) chk("m_op1", ex_op1, e.op1);
      if (e.c_rd) chk("m_rd", ex_rd, e.rd);
      if (e.c_imm) chk("m_imm", ex_imm, e.imm);
      if (e.c_f3) chk("m_funct3", ex_funct3, e.f3);
   endtask

   function automatic logic [31:0] gen_instr();
      logic [6:0] op, f7;
      logic [4:0] r1, r2, rdv;
      logic [2:0] f3;
      case ($urandom_range(0, 11))
         0:       op = 7'h33;
         1:       op = 7'h13;
         2, 3, 4: op = 7'h03;
         5:       op = 7'h23;
         6:       op = 7'h63;
         7:       op = 7'h37;
         8:       op = 7'h17;
         9:       op = 7'h6F;
         10:      op = 7'h67;
         default: op = 7'h00;
      endcase
      case ($urandom_range(0, 3))
         0, 1:    f7 = 7'h00;
         2:       f7 = 7'h20;
         default: f7 = 7'($urandom);
      endcase
      r1 = 5'($urandom_range(0, 3)); r2 = 5'($urandom_range(0, 3));
      rdv = 5'($urandom_range(0, 3)); f3 = 3'($urandom_range(0, 7));
      if (op == 7'h00) begin r1 = 0; r2 = 0; end
      return {f7, r2, r1, f3, rdv, op};
   endfunction

   // ---------------- directed vectors ----------------
   typedef struct packed {
      logic [31:0] instr, r1, r2, op1, op2, imm;
      logic [4:0]  alu, rd;
      logic rw, mr, mw, br, jp, ill, c_op1, c_op2, c_rd, c_imm;
   } vec_t;
   vec_t tv [15];

   exp_t        e, m_dec;
   logic [31:0] m_pc;
   logic        m_valid, m_bub, haz, exp_rdy;

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 0; out_ready = 1; flush = 0;
      end
   endtask

   initial begin
      tv[0]  = '{32'h002081B3, 32'd5, 32'd7, 32'd5, 32'd7, 32'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      tv[1]  = '{32'h402081B3, 32'd10, 32'd3, 32'd10, 32'd3, 32'd0, 5'd1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      tv[2]  = '{32'hABCDE2B7, 32'd0, 32'd0, 32'd0, 32'h000ABCDE, 32'd0, 5'd16, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      tv[3]  = '{32'h4040D093, 32'h80000000, 32'd0, 32'h80000000, 32'd4, 32'd0, 5'd7, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      tv[4]  = '{32'h00000000, 32'd1, 32'd2, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tv[5]  = '{32'h00208033, 32'd1, 32'd2, 32'd1, 32'd2, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      tv[6]  = '{32'hFFF10313, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 32'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      tv[7]  = '{32'h00209463, 32'd4, 32'd9, 32'd4, 32'd9, 32'd8, 5'd11, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      tv[8]  = '{32'h0020A223, 32'h100, 32'd55, 32'h100, 32'd4, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tv[9]  = '{32'h010000EF, 32'd0, 32'd0, 32'd0, 32'd16, 32'd0, 5'd18, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      tv[10] = '{32'h40009093, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tv[11] = '{32'h000110E7, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tv[12] = '{32'h0020F3B3, 32'hF0F0, 32'hFF00, 32'hF0F0, 32'hFF00, 32'd0, 5'd4, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      tv[13] = '{32'hFE20FEE3, 32'd3, 32'd3, 32'd3, 32'd3, 32'hFFFFFFFC, 5'd15, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      tv[14] = '{32'h0080A203, 32'h200, 32'd0, 32'h200, 32'd8, 32'd0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

      rst = 1; in_valid = 0; in_instr = 0; in_pc = 0; rs1_data = 0; rs2_data = 0; flush = 0; out_ready = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_ex_pc", ex_pc, RST_PC);
      chk("reset_alu", ex_alu_control, 0);
      chk("reset_reg_write", ex_reg_write, 0);
      @(negedge clk); rst = 0;
      @(posedge clk); #1;
      chk("idle_out_valid", out_valid, 0);
      chk("idle_in_ready", in_ready, 1);

      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         in_valid = 1; out_ready = 1; in_instr = tv[i].instr;
         rs1_data = tv[i].r1; rs2_data = tv[i].r2; in_pc = 32'h400 + 32'(i * 4);
         #1;
         chk("vec_in_ready", in_ready, 1);
         chk("vec_rs1_addr", rs1_addr, tv[i].instr[19:15]);
         chk("vec_rs2_addr", rs2_addr, tv[i].instr[24:20]);
         @(posedge clk); #1;
         chk("vec_out_valid", out_valid, 1);
         chk("vec_alu", ex_alu_control, tv[i].alu);
         chk("vec_reg_write", ex_reg_write, tv[i].rw);
         chk("vec_mem_read", ex_mem_read, tv[i].mr);
         chk("vec_mem_write", ex_mem_write, tv[i].mw);
         chk("vec_is_branch", ex_is_branch, tv[i].br);
         chk("vec_is_jump", ex_is_jump, tv[i].jp);
         chk("vec_illegal", ex_illegal, tv[i].ill);
         chk("vec_pc", ex_pc, 32'h400 + 32'(i * 4));
         if (tv[i].c_op1) chk("vec_op1", ex_op1, tv[i].op1);
         if (tv[i].c_op2) chk("vec_op2", ex_op2, tv[i].op2);
         if (tv[i].c_rd) chk("vec_rd", ex_rd, tv[i].rd);
         if (tv[i].c_imm) chk("vec_imm", ex_imm, tv[i].imm);
      end
      idle(3);

      // load-use: LW x4 then ADD x5,x4,x4
      @(negedge clk); in_valid = 1; in_instr = 32'h0000A203;
      @(posedge clk); #1; chk("lu_load_valid", out_valid, 1); chk("lu_load_mr", ex_mem_read, 1);
      @(negedge clk); in_instr = 32'h004202B3; #1; chk("lu_stall_ready", in_ready, 0);
      @(posedge clk); #1; chk("lu_bubble_valid", out_valid, 0);
      @(negedge clk); #1; chk("lu_bubble_ready", in_ready, 0);
      @(posedge clk); #1; chk("lu_bubble2_valid", out_valid, 0);
      @(negedge clk); #1; chk("lu_accept_ready", in_ready, 1);
      @(posedge clk); #1; chk("lu_add_valid", out_valid, 1); chk("lu_add_rd", ex_rd, 5); chk("lu_add_alu", ex_alu_control, 0);
      idle(2);
      // same with rd=x0: no stall
      @(negedge clk); in_valid = 1; in_instr = 32'h0000A003;
      @(posedge clk); #1; chk("lu0_valid", out_valid, 1); chk("lu0_reg_write", ex_reg_write, 0);
      @(negedge clk); in_instr = 32'h000002B3; #1; chk("lu0_ready", in_ready, 1);
      @(posedge clk); #1; chk("lu0_add_valid", out_valid, 1); chk("lu0_add_rd", ex_rd, 5);
      idle(2);

      // BNE held under backpressure, then flushed
      @(negedge clk); in_valid = 1; in_instr = 32'h00209463; rs1_data = 4; rs2_data = 9; out_ready = 0;
      @(posedge clk); #1; chk("hold_valid", out_valid, 1); chk("hold_alu", ex_alu_control, 11);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); in_instr = 32'h002081B3; rs1_data = 32'd77 + 32'(k); rs2_data = 32'd1;
         #1; chk("hold_in_ready", in_ready, 0);
         @(posedge clk); #1;
         chk("hold_out_valid", out_valid, 1);
         chk("hold_alu_stable", ex_alu_control, 11);
         chk("hold_op1_stable", ex_op1, 4);
         chk("hold_op2_stable", ex_op2, 9);
         chk("hold_imm_stable", ex_imm, 8);
      end
      @(negedge clk); flush = 1; #1; chk("flush_in_ready", in_ready, 0);
      @(posedge clk); #1; chk("flush_out_valid", out_valid, 0);
      @(negedge clk); flush = 0; in_valid = 0; out_ready = 1;
      @(posedge clk); #1; chk("flush_no_accept", out_valid, 0);

      // randomized traffic against the reference model
      m_valid = 0; m_bub = 0; m_dec = '0; m_pc = 0;
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         in_valid = ($urandom_range(0, 9) < 7);
         in_instr = gen_instr();
         in_pc = $urandom; rs1_data = $urandom; rs2_data = $urandom;
         out_ready = ($urandom_range(0, 9) < 6);
         flush = ($urandom_range(0, 19) == 0);
         e = ref_decode(in_instr, rs1_data, rs2_data);
         haz = in_valid && m_valid && m_dec.mr && (m_dec.rd != 0) &&
               ((e.u1 && in_instr[19:15] == m_dec.rd) || (e.u2 && in_instr[24:20] == m_dec.rd));
         exp_rdy = (!m_valid || out_ready) && !m_bub && !flush && !haz;
         #1;
         if (in_valid) chk("rand_in_ready", in_ready, exp_rdy);
         chk("rand_rs1_addr", rs1_addr, in_instr[19:15]);
         if (flush) begin
            m_valid = 0; m_bub = 0;
         end else if (in_valid && exp_rdy) begin
            m_valid = 1; m_dec = e; m_pc = in_pc; m_bub = 0;
         end else if (out_ready) begin
            m_bub = haz; m_valid = 0;
         end else begin
            m_bub = 0;
         end
         @(posedge clk); #1;
         chk("rand_out_valid", out_valid, m_valid);
         if (m_valid) check_model(m_dec, m_pc);
      end

      // reset in the middle of a held instruction
      idle(3);
      @(negedge clk); in_valid = 1; in_instr = 32'h002081B3; rs1_data = 5; rs2_data = 7; in_pc = 32'h80;
      @(posedge clk); #1; chk("mid_pre_valid", out_valid, 1);
      @(negedge clk); rst = 1; out_ready = 0;
      @(posedge clk); #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_pc", ex_pc, RST_PC);
      chk("mid_rst_alu_rd", {27'b0, ex_rd}, 0);
      @(negedge clk); rst = 0; in_valid = 0;
      @(posedge clk); #1; chk("mid_post_valid", out_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
